// File: rtl/div_pkg.sv
// Shared constants and state encoding for the div_32s restoring divider.
package div_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = $clog2(DIV_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_32s_if.sv
// Request/result bundle of the divider; the master requests, the divider is the slave.
interface div_32s_if
    import div_pkg::*;
#(
    parameter int N = DIV_W
);

    logic         start;
    logic [N-1:0] X;
    logic [N-1:0] Y;
    logic [N-1:0] Q;
    logic [N-1:0] R;
    logic         busy;
    logic         done;
    logic         div_zero;

    modport master (
        output start, X, Y,
        input  Q, R, busy, done, div_zero
    );

    modport slave (
        input  start, X, Y,
        output Q, R, busy, done, div_zero
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on {rem, quo}.
module div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem,
    input  logic [N-1:0] quo,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_nxt,
    output logic [N-1:0] quo_nxt
);

    logic [N:0] shifted;
    logic [N:0] trial;

    // rem < divisor holds every step, so a set top bit of trial means a negative trial.
    always_comb begin
        shifted = {rem, quo[N-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[N]) begin
            rem_nxt = trial[N-1:0];
        end else begin
            rem_nxt = shifted[N-1:0];
        end
        quo_nxt = {quo[N-2:0], ~trial[N]};
    end

endmodule

// File: rtl/div_32s.sv
// Sequential radix-2 restoring divider, N cycles per result, 1 cycle for divide-by-zero.
// Define DIV_SIGNED_EN for two's-complement operands with truncating division.
module div_32s
    import div_pkg::*;
#(
    parameter int N = DIV_W
) (
    input  logic          clk,
    input  logic          rst_n,
    div_32s_if.slave      bus
);

    localparam int            CW   = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    div_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] rem_q, rem_d;
    logic [N-1:0] quo_q, quo_d;
    logic [N-1:0] dvs_q, dvs_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] r_q, r_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         div_zero_q, div_zero_d;

    logic [N-1:0] rem_nxt, quo_nxt;
    logic [N-1:0] x_mag, y_mag, q_fin, r_fin, q_dz, r_dz;

    div_step #(.N(N)) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (dvs_q),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

`ifdef DIV_SIGNED_EN
    logic sx_q, sx_d;
    logic sy_q, sy_d;

    // The core divides magnitudes; signs are restored at write-back.
    always_comb begin
        x_mag = bus.X[N-1] ? -bus.X : bus.X;
        y_mag = bus.Y[N-1] ? -bus.Y : bus.Y;
        q_fin = (sx_q ^ sy_q) ? -quo_nxt : quo_nxt;
        r_fin = sx_q ? -rem_nxt : rem_nxt;
        q_dz  = sx_q ? N'(1) : '1;
        r_dz  = sx_q ? -quo_q : quo_q;
    end
`else
    always_comb begin
        x_mag = bus.X;
        y_mag = bus.Y;
        q_fin = quo_nxt;
        r_fin = rem_nxt;
        q_dz  = '1;
        r_dz  = quo_q;
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        q_d        = q_q;
        r_d        = r_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
`ifdef DIV_SIGNED_EN
        sx_d       = sx_q;
        sy_d       = sy_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    quo_d   = x_mag;
                    dvs_d   = y_mag;
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
`ifdef DIV_SIGNED_EN
                    sx_d    = bus.X[N-1];
                    sy_d    = bus.Y[N-1];
`endif
                end
            end
            CALC: begin
                if (cnt_q == '0 && dvs_q == '0) begin
                    q_d        = q_dz;
                    r_d        = r_dz;
                    div_zero_d = 1'b1;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = DONE;
                end else begin
                    rem_d = rem_nxt;
                    quo_d = quo_nxt;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        q_d        = q_fin;
                        r_d        = r_fin;
                        div_zero_d = 1'b0;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            q_q        <= '0;
            r_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            sx_q       <= 1'b0;
            sy_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            q_q        <= q_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
`ifdef DIV_SIGNED_EN
            sx_q       <= sx_d;
            sy_q       <= sy_d;
`endif
        end
    end

    assign bus.Q        = q_q;
    assign bus.R        = r_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_div_32s.sv
// Directed self-checking bench for div_32s; inputs driven and outputs sampled on the falling edge.
module tb_div_32s;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    div_32s_if #(.N(32)) bus ();

    div_32s #(.N(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive start for exactly one rising edge; returns at the falling edge after acceptance.
    task automatic pulse_start(input logic [31:0] x, input logic [31:0] y);
        bus.X     = x;
        bus.Y     = y;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit timed_out);
        cyc       = 0;
        timed_out = 1'b1;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.X     = '0;
        bus.Y     = '0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.Q !== 32'd0 || bus.R !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_qr: Q=%h R=%h want 0 0", bus.Q, bus.R);
        end
        total++;
        if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_flags: busy/done/dz=%b want 000", {bus.busy, bus.done, bus.div_zero});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        bit to;
        pulse_start(32'd100, 32'd7);
        bus.X = 32'hDEAD_BEEF;
        bus.Y = 32'd3;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL basic_busy: busy=%b want 1", bus.busy);
        end
        wait_done(cyc, to);
        total++;
        if (to || cyc != 32) begin
            bad++;
            $display("[TB] FAIL basic_latency: cycles=%0d timeout=%0d want 32", cyc, to);
        end
        total++;
        if (bus.Q !== 32'd14 || bus.R !== 32'd2 || bus.div_zero !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_result: Q=%0d R=%0d dz=%b busy=%b want 14 2 0 0", bus.Q, bus.R, bus.div_zero, bus.busy);
        end
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0 || bus.Q !== 32'd14 || bus.R !== 32'd2) begin
            bad++;
            $display("[TB] FAIL basic_hold: done=%b Q=%0d R=%0d want 0 14 2", bus.done, bus.Q, bus.R);
        end
    endtask

    task automatic test_boundaries();
        int cyc;
        bit to;
        logic [31:0] exp_q;
        pulse_start(32'hFFFF_FFFF, 32'd1);
        wait_done(cyc, to);
        total++;
        if (to || bus.Q !== 32'hFFFF_FFFF || bus.R !== 32'd0) begin
            bad++;
            $display("[TB] FAIL max_by_one: Q=%h R=%h timeout=%0d want ffffffff 0", bus.Q, bus.R, to);
        end
`ifdef DIV_SIGNED_EN
        exp_q = 32'hFFFF_FFFB;
`else
        exp_q = 32'd0;
`endif
        pulse_start(32'd5, 32'hFFFF_FFFF);
        wait_done(cyc, to);
        total++;
        if (to || bus.Q !== exp_q || bus.R !== 32'd0 + ((exp_q == 32'd0) ? 32'd5 : 32'd0)) begin
            bad++;
            $display("[TB] FAIL small_by_max: Q=%h R=%h timeout=%0d want Q=%h", bus.Q, bus.R, to, exp_q);
        end
    endtask

    task automatic test_div_zero();
        int cyc;
        bit to;
        pulse_start(32'd1234, 32'd0);
        wait_done(cyc, to);
        total++;
        if (to || cyc != 1) begin
            bad++;
            $display("[TB] FAIL dz_latency: cycles=%0d timeout=%0d want 1", cyc, to);
        end
        total++;
        if (bus.Q !== 32'hFFFF_FFFF || bus.R !== 32'd1234 || bus.div_zero !== 1'b1) begin
            bad++;
            $display("[TB] FAIL dz_result: Q=%h R=%0d dz=%b want ffffffff 1234 1", bus.Q, bus.R, bus.div_zero);
        end
        repeat (3) @(negedge clk);
        total++;
        if (bus.div_zero !== 1'b1 || bus.done !== 1'b0 || bus.R !== 32'd1234) begin
            bad++;
            $display("[TB] FAIL dz_hold: dz=%b done=%b R=%0d want 1 0 1234", bus.div_zero, bus.done, bus.R);
        end
`ifdef DIV_SIGNED_EN
        pulse_start(32'hFFFF_FFFB, 32'd0);
        wait_done(cyc, to);
        total++;
        if (to || bus.Q !== 32'd1 || bus.R !== 32'hFFFF_FFFB || bus.div_zero !== 1'b1) begin
            bad++;
            $display("[TB] FAIL dz_negative: Q=%h R=%h dz=%b want 1 fffffffb 1", bus.Q, bus.R, bus.div_zero);
        end
`endif
    endtask

    task automatic test_reset_abort();
        int cyc;
        bit to;
        int done_seen;
        done_seen = 0;
        pulse_start(32'd1000, 32'd10);
        for (int i = 1; i < 20; i++) begin
            bus.start = (i == 9);
            if (i == 9) begin
                bus.X = 32'd9;
                bus.Y = 32'd3;
            end
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || done_seen != 0) begin
            bad++;
            $display("[TB] FAIL abort_inflight: busy=%b dones=%0d want 1 0", bus.busy, done_seen);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (bus.Q !== 32'd0 || bus.R !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_reset: Q=%h R=%h busy=%b done=%b dz=%b want all 0", bus.Q, bus.R, bus.busy, bus.done, bus.div_zero);
        end
        repeat (40) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        total++;
        if (done_seen != 0) begin
            bad++;
            $display("[TB] FAIL abort_no_done: dones=%0d want 0", done_seen);
        end
        pulse_start(32'd9, 32'd3);
        wait_done(cyc, to);
        total++;
        if (to || bus.Q !== 32'd3 || bus.R !== 32'd0) begin
            bad++;
            $display("[TB] FAIL abort_restart: Q=%0d R=%0d timeout=%0d want 3 0", bus.Q, bus.R, to);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit to;
        pulse_start(32'd1000, 32'd10);
        wait_done(cyc, to);
        total++;
        if (to || bus.Q !== 32'd100 || bus.R !== 32'd0) begin
            bad++;
            $display("[TB] FAIL b2b_first: Q=%0d R=%0d timeout=%0d want 100 0", bus.Q, bus.R, to);
        end
        // Start is raised while done is still high; the next edge must accept it.
        pulse_start(32'd77, 32'd8);
        total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_accept: busy=%b done=%b want 1 0", bus.busy, bus.done);
        end
        wait_done(cyc, to);
        total++;
        if (to || cyc + 1 != 33) begin
            bad++;
            $display("[TB] FAIL b2b_spacing: done-to-done=%0d timeout=%0d want 33", cyc + 1, to);
        end
        total++;
        if (bus.Q !== 32'd9 || bus.R !== 32'd5) begin
            bad++;
            $display("[TB] FAIL b2b_second: Q=%0d R=%0d want 9 5", bus.Q, bus.R);
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        int cyc;
        bit to;
        pulse_start(32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, to);
        total++;
        if (to || bus.Q !== 32'hFFFF_FFFD || bus.R !== 32'hFFFF_FFFF) begin
            bad++;
            $display("[TB] FAIL signed_m7_2: Q=%h R=%h want fffffffd ffffffff", bus.Q, bus.R);
        end
        pulse_start(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, to);
        total++;
        if (to || bus.Q !== 32'h8000_0000 || bus.R !== 32'd0 || bus.div_zero !== 1'b0) begin
            bad++;
            $display("[TB] FAIL signed_overflow: Q=%h R=%h dz=%b want 80000000 0 0", bus.Q, bus.R, bus.div_zero);
        end
    endtask
`endif

    task automatic test_random();
        int cyc;
        bit to;
        logic [31:0] x, y, eq, er;
        for (int i = 0; i < 300; i++) begin
            x = $urandom;
            y = $urandom >> $urandom_range(0, 31);
            if (y == 32'd0) y = 32'd1;
`ifdef DIV_SIGNED_EN
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) y = 32'd3;
            eq = $signed(x) / $signed(y);
            er = $signed(x) % $signed(y);
`else
            eq = x / y;
            er = x % y;
`endif
            pulse_start(x, y);
            wait_done(cyc, to);
            total++;
            if (to || cyc != 32 || bus.Q !== eq || bus.R !== er) begin
                bad++;
                $display("[TB] FAIL random_%0d: X=%h Y=%h got Q=%h R=%h cyc=%0d want Q=%h R=%h cyc=32", i, x, y, bus.Q, bus.R, cyc, eq, er);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_reset_abort();
        test_back_to_back();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
